// File: rtl/imem_pkg.sv
// Shared types and default sizes for the instruction-memory port arbiter.
package imem_pkg;

    localparam int IMEM_W_DEF = 14;
    localparam int W_DEF      = 32;
    localparam int BE_W_DEF   = W_DEF / 8;

    typedef enum logic {
        GNT_FETCH  = 1'b0,
        GNT_LOADER = 1'b1
    } imem_gnt_e;

    typedef struct packed {
        logic                  we;
        logic [BE_W_DEF-1:0]   be;
        logic [IMEM_W_DEF-1:0] addr;
        logic [W_DEF-1:0]      wdata;
    } l_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the fetch side can be masked off (loader lock).
module rr_arb2
    import imem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_f,
    input  logic req_l,
    input  logic mask_f,
    output logic gnt_f,
    output logic gnt_l
);

    imem_gnt_e last_grant;
    logic      req_f_eff;

    // Grant decision: lone requester wins, contention goes to the one not served last.
    always_comb begin
        req_f_eff = req_f & ~mask_f;
        gnt_f     = 1'b0;
        gnt_l     = 1'b0;
        if (req_f_eff && req_l) begin
            gnt_f = (last_grant == GNT_LOADER);
            gnt_l = (last_grant == GNT_FETCH);
        end else begin
            gnt_f = req_f_eff;
            gnt_l = req_l;
        end
    end

    // Remember who was served; a grant is always a transfer because grant implies valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GNT_LOADER;
        end else if (gnt_f) begin
            last_grant <= GNT_FETCH;
        end else if (gnt_l) begin
            last_grant <= GNT_LOADER;
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction memory between fetch (read-only) and loader (read/write).
// Reads are combinational in the memory; responses are registered here (1-cycle latency).
module imem_port_arbiter
    import imem_pkg::*;
#(
    parameter int IMEM_W = IMEM_W_DEF,
    parameter int W      = W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              f_req_valid_i,
    output logic              f_req_ready_o,
    input  logic [IMEM_W-1:0] f_addr_i,
    output logic              f_rsp_valid_o,
    output logic [W-1:0]      f_rsp_data_o,
    input  logic              l_req_valid_i,
    output logic              l_req_ready_o,
    input  logic              l_we_i,
    input  logic [W/8-1:0]    l_be_i,
    input  logic [IMEM_W-1:0] l_addr_i,
    input  logic [W-1:0]      l_wdata_i,
    input  logic              l_lock_i,
    output logic              l_rsp_valid_o,
    output logic [W-1:0]      l_rsp_data_o,
    output logic [IMEM_W-3:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [W/8-1:0]    mem_be_o,
    output logic [W-1:0]      mem_wdata_o,
    input  logic [W-1:0]      mem_rdata_i
);

    l_req_t            l_req;
    logic              gnt_f;
    logic              gnt_l;
    logic [IMEM_W-3:0] addr_q;
    logic              f_rsp_valid_q;
    logic              l_rsp_valid_q;
    logic              unused_addr_bits;

    assign l_req.we    = l_we_i;
    assign l_req.be    = l_be_i;
    assign l_req.addr  = l_addr_i;
    assign l_req.wdata = l_wdata_i;

    assign unused_addr_bits = ^{f_addr_i[1:0], l_req.addr[1:0]};

    // Requests are suppressed during reset so no grant and no write can happen in a reset cycle.
    rr_arb2 u_arb (
        .clk    (clk_i),
        .rst    (rst_i),
        .req_f  (f_req_valid_i & ~rst_i),
        .req_l  (l_req_valid_i & ~rst_i),
        .mask_f (l_lock_i),
        .gnt_f  (gnt_f),
        .gnt_l  (gnt_l)
    );

    assign f_req_ready_o = gnt_f;
    assign l_req_ready_o = gnt_l;

    // Memory-side mux: granted port drives the address; idle cycles replay the last address.
    always_comb begin
        mem_addr_o  = addr_q;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (gnt_f) begin
            mem_addr_o = f_addr_i[IMEM_W-1:2];
        end else if (gnt_l) begin
            mem_addr_o = l_req.addr[IMEM_W-1:2];
            if (l_req.we) begin
                mem_we_o    = 1'b1;
                mem_be_o    = l_req.be;
                mem_wdata_o = l_req.wdata;
            end
        end
    end

    // Hold the last granted word address for idle cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
        end else if (gnt_f || gnt_l) begin
            addr_q <= mem_addr_o;
        end
    end

    // Capture read data into the owning port's response register; data holds between responses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            f_rsp_valid_q <= 1'b0;
            l_rsp_valid_q <= 1'b0;
            f_rsp_data_o  <= '0;
            l_rsp_data_o  <= '0;
        end else begin
            f_rsp_valid_q <= gnt_f;
            l_rsp_valid_q <= gnt_l & ~l_req.we;
            if (gnt_f) begin
                f_rsp_data_o <= mem_rdata_i;
            end
            if (gnt_l && !l_req.we) begin
                l_rsp_data_o <= mem_rdata_i;
            end
        end
    end

    // A response due in a reset cycle is cancelled immediately, not one cycle later.
    assign f_rsp_valid_o = f_rsp_valid_q & ~rst_i;
    assign l_rsp_valid_o = l_rsp_valid_q & ~rst_i;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: behavioural reference plus directed literal checks.
module tb_imem_port_arbiter;

    localparam int IMEM_W = 14;
    localparam int W      = 32;
    localparam int NWORDS = 1 << (IMEM_W - 2);

    logic              clk;
    logic              rst;
    logic              f_req_valid;
    logic              f_req_ready;
    logic [IMEM_W-1:0] f_addr;
    logic              f_rsp_valid;
    logic [W-1:0]      f_rsp_data;
    logic              l_req_valid;
    logic              l_req_ready;
    logic              l_we;
    logic [W/8-1:0]    l_be;
    logic [IMEM_W-1:0] l_addr;
    logic [W-1:0]      l_wdata;
    logic              l_lock;
    logic              l_rsp_valid;
    logic [W-1:0]      l_rsp_data;
    logic [IMEM_W-3:0] mem_addr;
    logic              mem_we;
    logic [W/8-1:0]    mem_be;
    logic [W-1:0]      mem_wdata;
    logic [W-1:0]      mem_rdata;

    int total = 0;
    int bad   = 0;

    imem_port_arbiter #(.IMEM_W(IMEM_W), .W(W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .f_req_valid_i (f_req_valid),
        .f_req_ready_o (f_req_ready),
        .f_addr_i      (f_addr),
        .f_rsp_valid_o (f_rsp_valid),
        .f_rsp_data_o  (f_rsp_data),
        .l_req_valid_i (l_req_valid),
        .l_req_ready_o (l_req_ready),
        .l_we_i        (l_we),
        .l_be_i        (l_be),
        .l_addr_i      (l_addr),
        .l_wdata_i     (l_wdata),
        .l_lock_i      (l_lock),
        .l_rsp_valid_o (l_rsp_valid),
        .l_rsp_data_o  (l_rsp_data),
        .mem_addr_o    (mem_addr),
        .mem_we_o      (mem_we),
        .mem_be_o      (mem_be),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory attached to the DUT, and the reference copy used by the model.
    logic [W-1:0] mem  [NWORDS];
    logic [W-1:0] rmem [NWORDS];

    initial begin
        for (int i = 0; i < NWORDS; i++) begin
            mem[i]  = 32'hC0DE_0000 | i;
            rmem[i] = 32'hC0DE_0000 | i;
        end
        mem[32]  = 32'h1122_3344;
        rmem[32] = 32'h1122_3344;
    end

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < W/8; b++) begin
                if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who is granted follows directly from valids, lock and who was served last.
    int           m_last;   // 1 = fetch served last, 2 = loader served last
    logic [11:0]  m_addr;
    logic         armed = 1'b0;
    logic         exp_fv, exp_lv;
    logic [W-1:0] exp_fd, exp_ld;
    int           g;
    logic [11:0]  e_addr;
    logic [11:0]  fw, lw;

    always @(negedge clk) begin
        fw = f_addr[13:2];
        lw = l_addr[13:2];
        if (rst) g = 0;
        else if (f_req_valid && !l_lock && l_req_valid) g = (m_last == 1) ? 2 : 1;
        else if (f_req_valid && !l_lock) g = 1;
        else if (l_req_valid) g = 2;
        else g = 0;
        e_addr = (g == 1) ? fw : (g == 2) ? lw : m_addr;

        if (armed) begin
            chk("f_ready", f_req_ready, g == 1);
            chk("l_ready", l_req_ready, g == 2);
            if (!rst) chk("mem_addr", mem_addr, e_addr);
            chk("mem_we", mem_we, g == 2 && l_we);
            chk("mem_be", mem_be, (g == 2 && l_we) ? l_be : 4'h0);
            chk("mem_wdata", mem_wdata, (g == 2 && l_we) ? l_wdata : 32'h0);
            chk("f_rsp_valid", f_rsp_valid, exp_fv && !rst);
            chk("f_rsp_data", f_rsp_data, exp_fd);
            chk("l_rsp_valid", l_rsp_valid, exp_lv && !rst);
            chk("l_rsp_data", l_rsp_data, exp_ld);
        end

        if (rst) begin
            exp_fv = 1'b0; exp_lv = 1'b0;
            exp_fd = '0;   exp_ld = '0;
            m_last = 2;    m_addr = '0;
            armed  = 1'b1;
        end else begin
            exp_fv = (g == 1);
            exp_lv = (g == 2) && !l_we;
            if (g == 1) exp_fd = rmem[fw];
            if (g == 2 && !l_we) exp_ld = rmem[lw];
            if (g == 2 && l_we) begin
                for (int b = 0; b < W/8; b++)
                    if (l_be[b]) rmem[lw][8*b +: 8] = l_wdata[8*b +: 8];
            end
            if (g != 0) begin
                m_last = g;
                m_addr = e_addr;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; f_req_valid = 1'b0; f_addr = '0;
        l_req_valid = 1'b0; l_we = 1'b0; l_be = '0; l_addr = '0; l_wdata = '0; l_lock = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_f_valid", f_rsp_valid, 1'b0);
        chk("rst_f_data", f_rsp_data, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);

        // fetch-only streaming reads
        f_req_valid = 1'b1; f_addr = 14'h000;
        #1 chk("t1_ready", f_req_ready, 1'b1);
        tick(); chk("t1_v0", f_rsp_valid, 1'b1); chk("t1_d0", f_rsp_data, 32'hC0DE_0000);
        f_addr = 14'h004;
        #1 chk("t1_ready1", f_req_ready, 1'b1);
        tick(); chk("t1_d1", f_rsp_data, 32'hC0DE_0001);
        f_addr = 14'h008;
        tick(); chk("t1_d2", f_rsp_data, 32'hC0DE_0002);
        chk("t1_lv", l_rsp_valid, 1'b0);
        f_req_valid = 1'b0;

        // contention right after reset: F, L, F, L
        rst = 1'b1; tick(); rst = 1'b0;
        f_req_valid = 1'b1; f_addr = 14'h018;
        l_req_valid = 1'b1; l_we = 1'b0; l_addr = 14'h01C;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t2_fready", f_req_ready, (i % 2) == 0);
            chk("t2_lready", l_req_ready, (i % 2) == 1);
            tick();
            if (i % 2 == 0) begin
                chk("t2_fv", f_rsp_valid, 1'b1); chk("t2_fd", f_rsp_data, 32'hC0DE_0006);
                chk("t2_lv0", l_rsp_valid, 1'b0);
            end else begin
                chk("t2_lv", l_rsp_valid, 1'b1); chk("t2_ld", l_rsp_data, 32'hC0DE_0007);
                chk("t2_fv0", f_rsp_valid, 1'b0);
            end
        end
        f_req_valid = 1'b0; l_req_valid = 1'b0;

        // loader lock: write then read back with fetch also requesting
        l_lock = 1'b1; f_req_valid = 1'b1; f_addr = 14'h000;
        l_req_valid = 1'b1; l_we = 1'b1; l_be = 4'hF; l_addr = 14'h010; l_wdata = 32'hDEAD_BEEF;
        #1 chk("t3_fready_w", f_req_ready, 1'b0); chk("t3_we", mem_we, 1'b1);
        tick();
        l_we = 1'b0;
        #1 chk("t3_fready_r", f_req_ready, 1'b0); chk("t3_lready", l_req_ready, 1'b1);
        tick();
        chk("t3_lv", l_rsp_valid, 1'b1); chk("t3_ld", l_rsp_data, 32'hDEAD_BEEF);
        f_req_valid = 1'b0; l_req_valid = 1'b0; l_lock = 1'b0;

        // byte-enabled partial write, then read-after-write on the next cycle
        l_req_valid = 1'b1; l_we = 1'b1; l_be = 4'b0010; l_addr = 14'h080; l_wdata = 32'h0000_AB00;
        tick();
        l_we = 1'b0; l_be = 4'h0;
        tick();
        chk("t4_lv", l_rsp_valid, 1'b1); chk("t4_ld", l_rsp_data, 32'h1122_AB44);
        l_req_valid = 1'b0;

        // reset right after a fetch grant cancels the response and restores fetch priority
        f_req_valid = 1'b1; f_addr = 14'h004;
        tick();
        rst = 1'b1; f_req_valid = 1'b0;
        #1 chk("t5_fv_cancel", f_rsp_valid, 1'b0);
        tick();
        rst = 1'b0;
        chk("t5_fv_after", f_rsp_valid, 1'b0);
        f_req_valid = 1'b1; l_req_valid = 1'b1; l_we = 1'b0; l_addr = 14'h000;
        #1 chk("t5_fready", f_req_ready, 1'b1); chk("t5_lready", l_req_ready, 1'b0);
        tick();
        f_req_valid = 1'b0; l_req_valid = 1'b0;

        // misaligned fetch address
        f_req_valid = 1'b1; f_addr = 14'h00F;
        #1 chk("t6_addr", mem_addr, 32'h3);
        tick();
        chk("t6_d", f_rsp_data, 32'hC0DE_0003);
        f_req_valid = 1'b0;
        #1 chk("t6_hold", mem_addr, 32'h3);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
